tpram_arbiter: RTL and testbench

- Shares one two-port RAM (16-bit data, 256 deep, write port A, read port B) between NREQ requesters.
- Each requester issues single-beat reads or writes over a valid/ready handshake.
- Writes are arbitrated onto port A and reads onto port B, each by its own round-robin arbiter.
- Read data is routed back to the issuing requester one cycle after acceptance.

---
 rtl/tpram_pkg.sv | 14 +
 rtl/rr_arb.sv | 55 +++++
 rtl/tpram_arbiter.sv | 88 ++++++++
 tb/tb_tpram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpram_pkg.sv
// Shared constants for the two-port RAM arbiter.
package tpram_pkg;

    localparam int unsigned RAM_AW       = 8;
    localparam int unsigned RAM_DW       = 16;
    localparam int unsigned RAM_DEPTH    = 256;
    localparam int unsigned NREQ_DEFAULT = 2;

    // Width of a pointer that indexes n requesters (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first candidate at or after the pointer,
// searching upward with wrap; the pointer moves past the winner on advance.
module rr_arb
    import tpram_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] cand,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

    localparam int unsigned PW = ptr_width(NREQ);
    localparam int          N  = int'(NREQ);

    logic [PW-1:0] ptr_q, ptr_d;

    // Priority search starting at the pointer, plus next-pointer selection.
    always_comb begin
        int  idx;
        int  nxt;
        logic found;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        nxt   = 0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && cand[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt      = (idx + 1 == N) ? 0 : idx + 1;
            end
        end
        if (advance && found) begin
            ptr_d = PW'(nxt);
        end
    end

    // Pointer register; reset gives requester 0 top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tpram_arbiter.sv
// Shares a two-port RAM between NREQ requesters: writes are arbitrated onto
// port A, reads onto port B, and read data is routed back one cycle later.
module tpram_arbiter
    import tpram_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned AW   = RAM_AW,
    parameter int unsigned DW   = RAM_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 ram_wea,
    output logic [AW-1:0]        ram_addra,
    output logic [DW-1:0]        ram_data_a,
    output logic                 ram_enb,
    output logic [AW-1:0]        ram_addrb,
    input  logic [DW-1:0]        ram_data_b
);

    logic [NREQ-1:0] wr_cand, rd_cand;
    logic [NREQ-1:0] wr_gnt, rd_gnt;
    logic [NREQ-1:0] rsp_tag_q, rsp_tag_d;

    assign wr_cand = req_valid & req_we;
    assign rd_cand = req_valid & ~req_we;

    // Ready is the grant itself, so every grant is a transfer and always advances.
    rr_arb #(
        .NREQ (NREQ)
    ) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .cand    (wr_cand),
        .advance (1'b1),
        .gnt     (wr_gnt)
    );

    rr_arb #(
        .NREQ (NREQ)
    ) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .cand    (rd_cand),
        .advance (1'b1),
        .gnt     (rd_gnt)
    );

    assign req_ready = wr_gnt | rd_gnt;

    // One-hot grant muxes onto the RAM ports; fields are zero with no grant.
    always_comb begin
        ram_addra  = '0;
        ram_data_a = '0;
        ram_addrb  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            ram_addra  = ram_addra  | (req_addr[i*AW +: AW]  & {AW{wr_gnt[i]}});
            ram_data_a = ram_data_a | (req_wdata[i*DW +: DW] & {DW{wr_gnt[i]}});
            ram_addrb  = ram_addrb  | (req_addr[i*AW +: AW]  & {AW{rd_gnt[i]}});
        end
        ram_wea = |wr_gnt;
        ram_enb = |rd_gnt;
    end

    // The response tag is simply this cycle's read grant.
    always_comb begin
        rsp_tag_d = rd_gnt;
    end

    // Response tag register; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_tag_q <= '0;
        end else begin
            rsp_tag_q <= rsp_tag_d;
        end
    end

    assign rsp_valid = rsp_tag_q;
    assign rsp_data  = ram_data_b;

endmodule

// File: tb/tb_tpram_arbiter.sv
// Bench for tpram_arbiter: directed vectors on a 2-requester instance and
// randomized traffic against a reference model on a 4-requester instance.
module tb_tpram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 2-requester instance ----------------
    logic [1:0]  r2_valid, r2_we;
    logic [15:0] r2_addr;
    logic [31:0] r2_wdata;
    logic [1:0]  w2_ready, w2_rsp_valid;
    logic [15:0] w2_rsp_data;
    logic        w2_wea, w2_enb;
    logic [7:0]  w2_addra, w2_addrb;
    logic [15:0] w2_data_a;
    logic [15:0] ram2_q = 16'h0;
    logic [15:0] ram2 [256] = '{default: 16'h0};

    tpram_arbiter #(.NREQ(2), .AW(8), .DW(16)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (r2_valid),
        .req_we     (r2_we),
        .req_addr   (r2_addr),
        .req_wdata  (r2_wdata),
        .req_ready  (w2_ready),
        .rsp_valid  (w2_rsp_valid),
        .rsp_data   (w2_rsp_data),
        .ram_wea    (w2_wea),
        .ram_addra  (w2_addra),
        .ram_data_a (w2_data_a),
        .ram_enb    (w2_enb),
        .ram_addrb  (w2_addrb),
        .ram_data_b (ram2_q)
    );

    always @(posedge clk) begin
        if (w2_wea) ram2[w2_addra] <= w2_data_a;
        if (w2_enb) ram2_q <= ram2[w2_addrb];
    end

    // ---------------- 4-requester instance ----------------
    logic [3:0]  r4_valid, r4_we;
    logic [31:0] r4_addr;
    logic [63:0] r4_wdata;
    logic [3:0]  w4_ready, w4_rsp_valid;
    logic [15:0] w4_rsp_data;
    logic        w4_wea, w4_enb;
    logic [7:0]  w4_addra, w4_addrb;
    logic [15:0] w4_data_a;
    logic [15:0] ram4_q = 16'h0;
    logic [15:0] ram4 [256] = '{default: 16'h0};

    tpram_arbiter #(.NREQ(4), .AW(8), .DW(16)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (r4_valid),
        .req_we     (r4_we),
        .req_addr   (r4_addr),
        .req_wdata  (r4_wdata),
        .req_ready  (w4_ready),
        .rsp_valid  (w4_rsp_valid),
        .rsp_data   (w4_rsp_data),
        .ram_wea    (w4_wea),
        .ram_addra  (w4_addra),
        .ram_data_a (w4_data_a),
        .ram_enb    (w4_enb),
        .ram_addrb  (w4_addrb),
        .ram_data_b (ram4_q)
    );

    always @(posedge clk) begin
        if (w4_wea) ram4[w4_addra] <= w4_data_a;
        if (w4_enb) ram4_q <= ram4[w4_addrb];
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First candidate at or after ptr, wrapping over 4 requesters; -1 if none.
    function automatic int pick(input logic [3:0] cand, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (cand[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  rdy;
        logic        wea;
        logic [7:0]  addra;
        logic [15:0] dataa;
        logic        enb;
        logic [7:0]  addrb;
        logic [1:0]  rsp;
        logic [15:0] rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic [1:0] valid, input logic [1:0] we,
        input logic [7:0] a0, input logic [7:0] a1,
        input logic [15:0] d0, input logic [15:0] d1,
        input logic [1:0] rdy, input logic wea, input logic [7:0] addra,
        input logic [15:0] dataa, input logic enb, input logic [7:0] addrb,
        input logic [1:0] rsp, input logic [15:0] rdata);
        vec_t v;
        v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.rdy = rdy; v.wea = wea; v.addra = addra; v.dataa = dataa;
        v.enb = enb; v.addrb = addrb; v.rsp = rsp; v.rdata = rdata;
        return v;
    endfunction

    vec_t vecs [15];

    // Reference-model state for the randomized phase.
    logic [15:0] mem_m [256];
    int          wp_m, rp_m;
    logic        pv  [4];
    logic        pwe [4];
    logic [7:0]  pa  [4];
    logic [15:0] pd  [4];

    initial begin
        logic [3:0]  wc, rc, exp_rdy, prev_rg;
        logic [15:0] prev_rd;
        int          wg, rg;

        // Directed vectors; one entry per cycle, pointers start at requester 0.
        vecs[0]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000,
                      2'b00, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 2'b00, 16'h0000);
        vecs[1]  = mk(2'b01, 2'b01, 8'h10, 8'h00, 16'hBEEF, 16'h0000,
                      2'b01, 1'b1, 8'h10, 16'hBEEF, 1'b0, 8'h00, 2'b00, 16'h0000);
        vecs[2]  = mk(2'b01, 2'b00, 8'h10, 8'h00, 16'h0000, 16'h0000,
                      2'b01, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 2'b00, 16'h0000);
        vecs[3]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000,
                      2'b00, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 2'b01, 16'hBEEF);
        // Write contention; write pointer sits at 1 after vector 1.
        vecs[4]  = mk(2'b11, 2'b11, 8'h01, 8'h02, 16'h0101, 16'h0202,
                      2'b10, 1'b1, 8'h02, 16'h0202, 1'b0, 8'h00, 2'b00, 16'h0000);
        vecs[5]  = mk(2'b11, 2'b11, 8'h01, 8'h02, 16'h0101, 16'h0202,
                      2'b01, 1'b1, 8'h01, 16'h0101, 1'b0, 8'h00, 2'b00, 16'h0000);
        vecs[6]  = mk(2'b11, 2'b11, 8'h01, 8'h02, 16'h0101, 16'h0202,
                      2'b10, 1'b1, 8'h02, 16'h0202, 1'b0, 8'h00, 2'b00, 16'h0000);
        vecs[7]  = mk(2'b11, 2'b11, 8'h01, 8'h02, 16'h0101, 16'h0202,
                      2'b01, 1'b1, 8'h01, 16'h0101, 1'b0, 8'h00, 2'b00, 16'h0000);
        // Same-cycle write and read of 0x20: read returns old data.
        vecs[8]  = mk(2'b11, 2'b01, 8'h20, 8'h20, 16'h1234, 16'h0000,
                      2'b11, 1'b1, 8'h20, 16'h1234, 1'b1, 8'h20, 2'b00, 16'h0000);
        vecs[9]  = mk(2'b10, 2'b00, 8'h00, 8'h20, 16'h0000, 16'h0000,
                      2'b10, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h20, 2'b10, 16'h0000);
        vecs[10] = mk(2'b11, 2'b11, 8'h30, 8'h31, 16'hAAAA, 16'h5555,
                      2'b10, 1'b1, 8'h31, 16'h5555, 1'b0, 8'h00, 2'b10, 16'h1234);
        vecs[11] = mk(2'b01, 2'b01, 8'h30, 8'h31, 16'hAAAA, 16'h5555,
                      2'b01, 1'b1, 8'h30, 16'hAAAA, 1'b0, 8'h00, 2'b00, 16'h0000);
        // Back-to-back reads from both requesters.
        vecs[12] = mk(2'b11, 2'b00, 8'h30, 8'h31, 16'h0000, 16'h0000,
                      2'b01, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h30, 2'b00, 16'h0000);
        vecs[13] = mk(2'b10, 2'b00, 8'h30, 8'h31, 16'h0000, 16'h0000,
                      2'b10, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h31, 2'b01, 16'hAAAA);
        vecs[14] = mk(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000,
                      2'b00, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 2'b10, 16'h5555);

        r2_valid = '0; r2_we = '0; r2_addr = '0; r2_wdata = '0;
        r4_valid = '0; r4_we = '0; r4_addr = '0; r4_wdata = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp2", 32'(w2_rsp_valid), 32'h0);
        chk("reset_rsp4", 32'(w4_rsp_valid), 32'h0);
        rst_n = 1'b1;

        // Table-driven directed vectors.
        for (int v = 0; v < 15; v++) begin
            r2_valid = vecs[v].valid;
            r2_we    = vecs[v].we;
            r2_addr  = {vecs[v].a1, vecs[v].a0};
            r2_wdata = {vecs[v].d1, vecs[v].d0};
            @(negedge clk);
            chk($sformatf("v%0d_ready", v), 32'(w2_ready), 32'(vecs[v].rdy));
            chk($sformatf("v%0d_wea", v), 32'(w2_wea), 32'(vecs[v].wea));
            chk($sformatf("v%0d_addra", v), 32'(w2_addra), 32'(vecs[v].addra));
            chk($sformatf("v%0d_data_a", v), 32'(w2_data_a), 32'(vecs[v].dataa));
            chk($sformatf("v%0d_enb", v), 32'(w2_enb), 32'(vecs[v].enb));
            chk($sformatf("v%0d_addrb", v), 32'(w2_addrb), 32'(vecs[v].addrb));
            chk($sformatf("v%0d_rsp_valid", v), 32'(w2_rsp_valid), 32'(vecs[v].rsp));
            if (vecs[v].rsp != 2'b00) begin
                chk($sformatf("v%0d_rsp_data", v), 32'(w2_rsp_data), 32'(vecs[v].rdata));
            end
            @(posedge clk);
            #1;
        end

        // Reset in the cycle after a read accept drops the response.
        r2_valid = 2'b01; r2_we = 2'b00; r2_addr = 16'h0040;
        @(negedge clk);
        chk("midrst_read_ready", 32'(w2_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        r2_valid = 2'b00;
        #1;
        chk("midrst_rsp_during", 32'(w2_rsp_valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r2_valid = 2'b11; r2_we = 2'b11; r2_addr = 16'h5150; r2_wdata = 32'h2222_1111;
        @(negedge clk);
        chk("postrst_rsp", 32'(w2_rsp_valid), 32'h0);
        chk("postrst_wr_ready", 32'(w2_ready), 32'h1);
        @(posedge clk);
        #1;
        r2_we = 2'b00;
        @(negedge clk);
        chk("postrst_rsp2", 32'(w2_rsp_valid), 32'h0);
        chk("postrst_rd_ready", 32'(w2_ready), 32'h1);
        @(posedge clk);
        #1;
        r2_valid = 2'b00;
        @(negedge clk);
        chk("postrst_rsp3", 32'(w2_rsp_valid), 32'h1);
        chk("postrst_rdata", 32'(w2_rsp_data), 32'h1111);
        @(posedge clk);
        #1;

        // Wrap with 4 requesters: move read pointer to 3, then candidates {3,0}.
        r4_valid = 4'b0100; r4_we = 4'b0000; r4_addr = 32'h0005_0000;
        @(negedge clk);
        chk("wrap_setup_ready", 32'(w4_ready), 32'h4);
        @(posedge clk);
        #1;
        r4_valid = 4'b1001; r4_addr = 32'h0700_0006;
        @(negedge clk);
        chk("wrap_grant3", 32'(w4_ready), 32'h8);
        @(posedge clk);
        #1;
        r4_valid = 4'b0001;
        @(negedge clk);
        chk("wrap_grant0", 32'(w4_ready), 32'h1);
        @(posedge clk);
        #1;
        r4_valid = 4'b1111;
        @(negedge clk);
        chk("wrap_ptr1", 32'(w4_ready), 32'h2);
        @(posedge clk);
        #1;
        r4_valid = 4'b0000;
        @(posedge clk);
        #1;

        // Randomized traffic against the model; pointers now write 0, read 2.
        wp_m = 0;
        rp_m = 2;
        prev_rg = '0;
        prev_rd = '0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0; pwe[i] = 1'b0; pa[i] = '0; pd[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, 3) != 0) begin
                    pv[i]  = 1'b1;
                    pwe[i] = 1'($urandom_range(0, 1));
                    pa[i]  = 8'($urandom_range(0, 7));
                    pd[i]  = 16'($urandom);
                end
                r4_valid[i]          = pv[i];
                r4_we[i]             = pwe[i];
                r4_addr[i*8 +: 8]    = pa[i];
                r4_wdata[i*16 +: 16] = pd[i];
            end
            wc = r4_valid & r4_we;
            rc = r4_valid & ~r4_we;
            wg = pick(wc, wp_m);
            rg = pick(rc, rp_m);
            exp_rdy = '0;
            if (wg >= 0) exp_rdy[wg] = 1'b1;
            if (rg >= 0) exp_rdy[rg] = 1'b1;
            @(negedge clk);
            chk($sformatf("rnd%0d_ready", cyc), 32'(w4_ready), 32'(exp_rdy));
            chk($sformatf("rnd%0d_wea", cyc), 32'(w4_wea), 32'(wg >= 0));
            chk($sformatf("rnd%0d_addra", cyc), 32'(w4_addra), (wg >= 0) ? 32'(pa[wg]) : 32'h0);
            chk($sformatf("rnd%0d_data_a", cyc), 32'(w4_data_a), (wg >= 0) ? 32'(pd[wg]) : 32'h0);
            chk($sformatf("rnd%0d_enb", cyc), 32'(w4_enb), 32'(rg >= 0));
            chk($sformatf("rnd%0d_addrb", cyc), 32'(w4_addrb), (rg >= 0) ? 32'(pa[rg]) : 32'h0);
            chk($sformatf("rnd%0d_rsp_valid", cyc), 32'(w4_rsp_valid), 32'(prev_rg));
            if (prev_rg != '0) begin
                chk($sformatf("rnd%0d_rsp_data", cyc), 32'(w4_rsp_data), 32'(prev_rd));
            end
            // Model update at the edge: read sees pre-write contents.
            prev_rg = '0;
            prev_rd = '0;
            if (rg >= 0) begin
                prev_rg[rg] = 1'b1;
                prev_rd     = mem_m[pa[rg]];
                rp_m        = (rg + 1) % 4;
                pv[rg]      = 1'b0;
            end
            if (wg >= 0) begin
                mem_m[pa[wg]] = pd[wg];
                wp_m          = (wg + 1) % 4;
                pv[wg]        = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
